approx_mult_err_sweep: RTL

//  Exhaustive error-characterisation stage for the 4x4 LUT/CARRY4 approximate multipliers.

---
 rtl/approx_mult_err_sweep.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/approx_mult_err_sweep.sv
// Sweeps every (A,B) pair through an external approximate multiplier, one pair per clock, and gathers error statistics.
// Latency: done pulses in the cycle after edge N+1+MULT_LAT counted from the start edge.
// Backpressure: none; the multiplier must accept one pair per clock, and start is ignored while busy.
module approx_mult_err_sweep #(
    parameter int W        = 4,
    parameter int MULT_LAT = 0,
    parameter int SUM_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [W-1:0]       mult_a,
    output logic [W-1:0]       mult_b,
    input  logic [2*W-1:0]     mult_r,
    output logic               busy,
    output logic               done,
    output logic [2*W:0]       err_count,
    output logic [SUM_W-1:0]   sum_ed,
    output logic               sum_sat,
    output logic [2*W-1:0]     max_ed,
    output logic [W-1:0]       max_a,
    output logic [W-1:0]       max_b
);
    localparam int PW = 2 * W;
    localparam int N  = 1 << PW;
    localparam int EW = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(N - 2);
    localparam logic [EW-1:0] SUM_MAX  = (EW'(1) << SUM_W) - EW'(1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    typedef struct packed {
        logic         vld;
        logic         last;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   idx, idx_inc;
    logic            issue_vld, issue_last;
    logic            sweep_go;
    op_t             issue_op, tap_op;
    logic            cap_vld, cap_last;
    logic [W-1:0]    cap_a, cap_b;
    logic [PW-1:0]   cap_r, cap_exact;
    logic [PW-1:0]   ed;
    logic [EW-1:0]   sum_wide;

    assign sweep_go = (state == IDLE) && start;
    assign idx_inc  = idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (idx == PRE_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cap_vld && cap_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand issue: idx low half drives A, high half drives B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            issue_vld  <= 1'b0;
            issue_last <= 1'b0;
        end else begin
            issue_vld  <= 1'b0;
            issue_last <= 1'b0;
            if (sweep_go) begin
                idx       <= '0;
                mult_a    <= '0;
                mult_b    <= '0;
                issue_vld <= 1'b1;
            end else if (state == SWEEP) begin
                idx        <= idx_inc;
                mult_a     <= idx_inc[W-1:0];
                mult_b     <= idx_inc[PW-1:W];
                issue_vld  <= 1'b1;
                issue_last <= (idx_inc == LAST_IDX);
            end
        end
    end

    assign issue_op = '{vld: issue_vld, last: issue_last, a: mult_a, b: mult_b};

    // Operands are delayed to line up with the multiplier's own register stages.
    generate
        if (MULT_LAT == 0) begin : g_nodly
            assign tap_op = issue_op;
        end else begin : g_dly
            op_t dly [MULT_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MULT_LAT; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= issue_op;
                    for (int i = 1; i < MULT_LAT; i++) dly[i] <= dly[i-1];
                end
            end
            assign tap_op = dly[MULT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld   <= 1'b0;
            cap_last  <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_r     <= '0;
            cap_exact <= '0;
        end else begin
            cap_vld   <= tap_op.vld;
            cap_last  <= tap_op.last;
            cap_a     <= tap_op.a;
            cap_b     <= tap_op.b;
            cap_r     <= mult_r;
            cap_exact <= PW'(tap_op.a) * PW'(tap_op.b);
        end
    end

    assign ed       = (cap_r >= cap_exact) ? (cap_r - cap_exact) : (cap_exact - cap_r);
    assign sum_wide = EW'(sum_ed) + EW'(ed);

    // Strict > keeps the operands of the first pair that reached the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            sum_sat   <= 1'b0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (sweep_go) begin
            err_count <= '0;
            sum_ed    <= '0;
            sum_sat   <= 1'b0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (cap_vld) begin
            if (ed != '0) err_count <= err_count + (PW+1)'(1);
            if (sum_wide > SUM_MAX) begin
                sum_ed  <= '1;
                sum_sat <= 1'b1;
            end else begin
                sum_ed <= sum_wide[SUM_W-1:0];
            end
            if (ed > max_ed) begin
                max_ed <= ed;
                max_a  <= cap_a;
                max_b  <= cap_b;
            end
        end
    end
endmodule
